// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes RV32 fields, tracks pending writers per register and holds one issue slot.
// Optional define DECODE_WB_BYPASS_EN forwards same-cycle writeback data into a waiting source operand.
module decode_issue_stage #(
  parameter int unsigned SB_CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic [4:0]  regA,
  output logic [4:0]  regB,
  input  logic [31:0] regA_data,
  input  logic [31:0] regB_data,
  input  logic        RegWriteEn,
  input  logic [4:0]  regD,
  input  logic [31:0] data_to_w,
  input  logic        kill_valid,
  input  logic [4:0]  kill_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_opA,
  output logic [31:0] out_opB,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_wr
);

  localparam int unsigned CW = SB_CNT_W + 1;
  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  // Entry 0 is kept at zero so x0 is never pending.
  logic [31:0][SB_CNT_W-1:0] cnt_q;
  logic [31:0][SB_CNT_W-1:0] cnt_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        is_store;
  logic        is_branch;
  logic        is_rtype;
  logic        uses_rs2;
  logic        writes_rd;
  logic [31:0] imm;

  assign opcode    = in_inst[6:0];
  assign rd        = in_inst[11:7];
  assign rs1       = in_inst[19:15];
  assign rs2       = in_inst[24:20];
  assign regA      = rs1;
  assign regB      = rs2;
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign uses_rs2  = is_rtype | is_store | is_branch;
  assign writes_rd = (rd != 5'd0) & ~is_store & ~is_branch;
  assign imm       = is_store ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]}
                              : {{20{in_inst[31]}}, in_inst[31:20]};

  logic slot_a;
  logic slot_b;
  logic pend_a;
  logic pend_b;
  logic haz_a;
  logic haz_b;
  logic haz_struct;
  logic hazard;
  logic [31:0] op_a;
  logic [31:0] op_b;

  // A source is pending if scoreboarded or about to be written by the instruction in the slot.
  assign slot_a = out_valid & out_wr & (out_rd == rs1);
  assign slot_b = out_valid & out_wr & (out_rd == rs2);
  assign pend_a = (rs1 != 5'd0) & ((cnt_q[rs1] != '0) | slot_a);
  assign pend_b = uses_rs2 & (rs2 != 5'd0) & ((cnt_q[rs2] != '0) | slot_b);

`ifdef DECODE_WB_BYPASS_EN
  logic byp_a;
  logic byp_b;

  // The last outstanding writer retiring this cycle can feed the operand directly.
  assign byp_a = RegWriteEn & (regD == rs1) & (cnt_q[rs1] == SB_CNT_W'(1)) & ~slot_a;
  assign byp_b = RegWriteEn & (regD == rs2) & (cnt_q[rs2] == SB_CNT_W'(1)) & ~slot_b;
  assign haz_a = pend_a & ~byp_a;
  assign haz_b = pend_b & ~byp_b;
  assign op_a  = (rs1 == 5'd0) ? 32'd0 : (byp_a ? data_to_w : regA_data);
  assign op_b  = (rs2 == 5'd0) ? 32'd0 : (byp_b ? data_to_w : regB_data);
`else
  logic unused_wb_data;

  assign unused_wb_data = ^data_to_w;
  assign haz_a = pend_a;
  assign haz_b = pend_b;
  assign op_a  = (rs1 == 5'd0) ? 32'd0 : regA_data;
  assign op_b  = (rs2 == 5'd0) ? 32'd0 : regB_data;
`endif

  assign haz_struct = writes_rd & (cnt_q[rd] == CNT_MAX);
  assign hazard     = haz_a | haz_b | haz_struct;
  assign in_ready   = (~out_valid | out_ready) & ~hazard & ~flush & ~reset;

  logic accept;
  logic issue;

  assign accept = in_valid & in_ready;
  assign issue  = out_valid & out_ready & out_wr & ~flush;

  // Net counter update; a decrement below zero holds the counter at zero.
  function automatic logic [SB_CNT_W-1:0] cnt_next(input logic [SB_CNT_W-1:0] cur,
                                                   input logic                inc,
                                                   input logic [1:0]          dec);
    logic [CW-1:0] sum;
    sum = CW'(cur) + CW'(inc);
    if (sum >= CW'(dec)) cnt_next = SB_CNT_W'(sum - CW'(dec));
    else                 cnt_next = '0;
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    cnt_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = cnt_next(cnt_q[r],
                          issue & (out_rd == 5'(r)),
                          2'(RegWriteEn & (regD == 5'(r))) + 2'(kill_valid & (kill_rd == 5'(r))));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      out_valid  <= 1'b0;
      out_opA    <= '0;
      out_opB    <= '0;
      out_imm    <= '0;
      out_rd     <= '0;
      out_opcode <= '0;
      out_funct3 <= '0;
      out_wr     <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid  <= 1'b1;
        out_opA    <= op_a;
        out_opB    <= op_b;
        out_imm    <= imm;
        out_rd     <= rd;
        out_opcode <= opcode;
        out_funct3 <= in_inst[14:12];
        out_wr     <= writes_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
